// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bridge
// Brief    : Single-outstanding CPU-to-MMIO bridge with region decode, lane
//            steering, per-access wait timeout and one-cycle responses.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bridge #(
    parameter int                         XLEN    = 32,
    parameter int                         NSLAVE  = 4,
    parameter logic [NSLAVE*XLEN-1:0]     BASES   = (NSLAVE*XLEN)'({32'h1000, 32'h0}),
    parameter logic [NSLAVE*XLEN-1:0]     MASKS   = (NSLAVE*XLEN)'({~32'h7, ~32'hFFF}),
    parameter int                         TIMEOUT = 255
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic [XLEN-1:0]          req_addr,
    input  logic [XLEN-1:0]          req_wdata,

    output logic                     rsp_valid,
    output logic [XLEN-1:0]          rsp_rdata,
    output logic                     rsp_err,

    output logic [NSLAVE-1:0]        s_sel,
    output logic                     s_write,
    output logic [XLEN-1:0]          s_addr,
    output logic [XLEN-1:0]          s_wdata,
    output logic [XLEN/8-1:0]        s_wstrb,
    input  logic [NSLAVE-1:0]        s_ready,
    input  logic [NSLAVE*XLEN-1:0]   s_rdata
);

    localparam int c_nbytes = XLEN / 8;
    localparam int c_offw   = $clog2(c_nbytes);
    localparam int c_cntw   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    logic [1:0]          r_state;
    logic [c_cntw-1:0]   r_cnt;
    logic [NSLAVE-1:0]   r_sel;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [1:0]          r_size;
    logic                r_write;
    logic [XLEN-1:0]     r_rdata;
    logic                r_err;

    logic [NSLAVE-1:0]   w_hit;
    logic [NSLAVE-1:0]   w_pick;
    logic                w_misalign;
    logic                w_bad_size;
    logic                w_dec_err;
    logic [c_offw-1:0]   w_off;
    logic [7:0]          w_strb_base;
    logic [c_nbytes-1:0] w_strb;
    logic [XLEN-1:0]     w_lane_mask;
    logic [XLEN-1:0]     w_sel_rdata;
    logic                w_sel_ready;
    logic [XLEN-1:0]     w_load_data;
    logic                w_in_access;

    // Region match per slave; overlaps are resolved by lowest-set-bit isolation.
    for (genvar i = 0; i < NSLAVE; i++) begin : g_decode
        assign w_hit[i] = (req_addr & MASKS[i*XLEN +: XLEN]) == BASES[i*XLEN +: XLEN];
    end

    assign w_pick = w_hit & (~w_hit + NSLAVE'(1));

    always_comb begin
        case (req_size)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            default: w_misalign = |req_addr[2:0];
        endcase
    end

    assign w_bad_size = (req_size == 2'd3) && (XLEN == 32);
    assign w_dec_err  = w_misalign | w_bad_size | ~(|w_hit);

    assign w_off = r_addr[c_offw-1:0];

    always_comb begin
        case (r_size)
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
    end

    assign w_strb = c_nbytes'(w_strb_base) << w_off;

    always_comb begin
        w_lane_mask = '0;
        for (int b = 0; b < c_nbytes; b++) begin
            if (w_strb_base[b]) begin
                w_lane_mask[b*8 +: 8] = 8'hFF;
            end
        end
    end

    // Only the selected slave contributes; ready from idle slaves is masked off.
    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (r_sel[i]) begin
                w_sel_rdata = w_sel_rdata | s_rdata[i*XLEN +: XLEN];
            end
        end
    end

    assign w_sel_ready = |(s_ready & r_sel);
    assign w_load_data = (w_sel_rdata >> {w_off, 3'b000}) & w_lane_mask;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= 2'd0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_write <= req_write;
                        r_cnt   <= '0;
                        r_rdata <= '0;
                        if (w_dec_err) begin
                            r_state <= c_st_resp;
                            r_err   <= 1'b1;
                            r_sel   <= '0;
                        end else begin
                            r_state <= c_st_access;
                            r_err   <= 1'b0;
                            r_sel   <= w_pick;
                        end
                    end
                end
                c_st_access: begin
                    if (w_sel_ready) begin
                        r_state <= c_st_resp;
                        r_err   <= 1'b0;
                        r_rdata <= r_write ? '0 : w_load_data;
                        r_sel   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_resp;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_sel   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cntw'(1);
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_in_access = (r_state == c_st_access);

    assign req_ready = (r_state == c_st_idle) && reset;
    assign rsp_valid = (r_state == c_st_resp);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = rsp_valid ? r_rdata : '0;

    assign s_sel   = w_in_access ? r_sel : '0;
    assign s_write = w_in_access & r_write;
    assign s_addr  = r_addr;
    assign s_wdata = r_wdata << {w_off, 3'b000};
    assign s_wstrb = (w_in_access && r_write) ? w_strb : '0;

endmodule
`default_nettype wire

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter NSLAVE, default 4, number of slave regions (1..8).
REQ-003 Parameter BASES, default {32'h1000,32'h0}, packed NSLAVE x XLEN region base addresses, index 0 in LSBs.
REQ-004 Parameter MASKS, default {~32'h7,~32'hFFF}, packed NSLAVE x XLEN match masks; slave i hits when (addr & MASKS[i]) == BASES[i].
REQ-005 Parameter TIMEOUT, default 255, maximum slave wait cycles before an error response.
REQ-006 clock  in  1  rising-edge clock; reset is synchronous and active-low.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 req_valid  in  1  CPU request present.
REQ-009 req_ready  out  1  bridge accepts a request this cycle.
REQ-010 req_write  in  1  1 = store, 0 = load.
REQ-011 req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
REQ-012 req_addr  in  XLEN  byte address.
REQ-013 req_wdata  in  XLEN  store data, right-aligned.
REQ-014 rsp_valid  out  1  one-cycle response pulse.
REQ-015 rsp_rdata  out  XLEN  load data, right-aligned, zero-extended above size.
REQ-016 rsp_err  out  1  qualifies rsp_valid: decode miss, misalignment or timeout.
REQ-017 s_sel  out  NSLAVE  one-hot slave select.
REQ-018 s_write, s_addr[XLEN], s_wdata[XLEN], s_wstrb[XLEN/8]  out  broadcast slave request, lane-positioned.
REQ-019 s_ready  in  NSLAVE  per-slave completion.
REQ-020 s_rdata  in  NSLAVE*XLEN  per-slave read data, lane-positioned.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; one transaction outstanding at a time.
REQ-022 req_ready = 1 only in IDLE; acceptance = req_valid & req_ready; address, size, write and wdata are registered on acceptance.
REQ-023 Decode on acceptance: lowest-index hitting slave wins on overlapping regions.
REQ-024 Misaligned (addr mod 2^size != 0), size 3 with XLEN=32, or no hit: IDLE -> RESP with rsp_err=1, rsp_rdata=0; no s_sel asserted.
REQ-025 Valid hit: IDLE -> ACCESS; s_sel[i] held high throughout ACCESS, s_addr = registered address.
REQ-026 Lane offset off = addr[log2(XLEN/8)-1:0]; s_wdata = wdata << 8*off; s_wstrb = ((1<<2^size)-1) << off; s_wstrb = 0 for loads.
REQ-027 ACCESS: wait counter starts at 0 and increments each cycle; s_ready[i]=1 -> capture (s_rdata[i] >> 8*off) masked to 2^size bytes; rsp_err=0; go to RESP.
REQ-028 Counter reaching TIMEOUT without s_ready[i] -> RESP with rsp_err=1, rsp_rdata=0; s_ready from unselected slaves is ignored.
REQ-029 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata/rsp_err valid only while rsp_valid=1, otherwise 0.
REQ-030 Latency: hit with s_ready in the first ACCESS cycle -> rsp_valid 2 cycles after acceptance; decode error -> 1 cycle.
REQ-031 Store responses return rsp_rdata=0.
REQ-032 A request held on req_valid outside IDLE is not accepted and is not lost; it is accepted on the next IDLE cycle.

Reset
REQ-033 reset=0 at a rising edge -> state IDLE, counter 0, s_sel=0, s_wstrb=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 while reset is low.
REQ-034 Reset during ACCESS aborts the transaction with no response; the first cycle after release has req_ready=1.

Verification
REQ-035 Byte store to 0x1001, wdata 0x5A, slave1 ready at once -> s_sel=0b0010, s_wdata=0x00005A00, s_wstrb=0b0010, rsp_valid 2 cycles later with err=0.
REQ-036 Half load at 0x0006, slave0 rdata 0xBEEF1234 after 3 wait cycles -> rsp_rdata=0x0000BEEF, err=0, rsp_valid 5 cycles after acceptance.
REQ-037 Word load at 0x0002 -> rsp_err=1 one cycle after acceptance, s_sel never asserted.
REQ-038 Load at 0x8000 (no hit) -> rsp_err=1, rsp_rdata=0; slave ready never asserted with TIMEOUT=4 on a hit -> rsp_err=1 on the 4th ACCESS cycle.
REQ-039 Back-to-back requests with req_valid held -> second accepted the cycle after the first rsp_valid, never during ACCESS/RESP.
REQ-040 reset=0 asserted mid-ACCESS -> no rsp_valid, all outputs 0; after reset=1, req_ready=1 and a new access completes normally.
